mvm_rf_weight_loader: RTL and testbench
=======================================

// Module: mvm_rf_weight_loader
// PURPOSE
// Upstream feeder for mvm_top's AXIS slave port. Turns a raw stream of weight words into single-beat AXIS
// register-file write flits: TUSER carries the RF address, the write opcode and a one-hot RF select.
// Consecutive words go to consecutive RFs at the same address. After the last RF, the address advances.
// Replaces bench-side flit construction so hardware can load weights.
// PARAMETERS
// DATAW   107  data width of a weight word and of output TDATA
// IDW     32   output TID width
// DESTW   12   output TDEST width
// USERW   75   output TUSER width; bits [USERW-1:11] are the one-hot RF select, so NUM_RF = USERW-11 = 64
// ADDRW   9    RF address width, carried in TUSER[8:0]
// PORTS
// CLK            in   1      single clock
// RST            in   1      asynchronous, active-high reset
// CFG_START      in   1      one-cycle pulse that starts a load; ignored while BUSY
// CFG_DEST       in   DESTW  TDEST for every flit of the load
// CFG_NUM_RF     in   7      RFs per address row, 0..64 (values above 64 are clamped to 64)
// CFG_DEPTH      in   10     address rows to write, 0..512
// CFG_BASE_ADDR  in   ADDRW  first RF address
// BUSY           out  1      a load is in progress
// DONE           out  1      one-cycle pulse when a load completes
// ERR            out  1      sticky early-TLAST error; cleared by the next accepted CFG_START
// S_TVALID/S_TREADY  in/out  1      weight-word input handshake
// S_TDATA        in   DATAW  weight word
// S_TLAST        in   1      marks the last word of the source stream
// AXIS_M_TVALID/AXIS_M_TREADY  out/in  1  flit output handshake
// AXIS_M_TDATA   out  DATAW  weight word
// AXIS_M_TUSER   out  USERW  [8:0] RF address, [10:9] = 2'b11 (write opcode), [11+k] = 1 for RF k only
// AXIS_M_TDEST   out  DESTW  latched CFG_DEST
// AXIS_M_TID     out  IDW    always 0
// AXIS_M_TLAST   out  1      always 1 while AXIS_M_TVALID is high (single-beat packets)
// BEHAVIOUR
// - Reset (async) clears all state. All outputs go to 0 immediately; FSM goes to IDLE. A reset mid-load drops the in-flight flit.
// - FSM states: IDLE, STREAM, DRAIN, FINISH.
//   - IDLE -> STREAM on CFG_START. Latch the config, set rf_idx=0 and addr=CFG_BASE_ADDR, clear ERR.
//   - IDLE -> FINISH on CFG_START if CFG_NUM_RF==0 or CFG_DEPTH==0. No flits are emitted.
//   - STREAM -> DRAIN when the final word (NUM_RF*DEPTH) or a word with S_TLAST is accepted.
//   - DRAIN -> FINISH when the output register holds no flit.
//   - FINISH -> IDLE after one cycle. DONE=1 during that cycle.
// - BUSY = (state != IDLE).
// - S_TREADY = (state==STREAM) && (!AXIS_M_TVALID || AXIS_M_TREADY). It is 0 in every other state, so surplus input words stay upstream.
// - Output is a single register stage: an input word accepted at edge N is presented at edge N+1 (latency 1).
//   Full throughput is 1 word/cycle while AXIS_M_TREADY=1.
// - AXIS_M_* stays stable while AXIS_M_TVALID=1 && AXIS_M_TREADY=0. Simultaneous output consume and input accept reloads the register in the same cycle.
// - Counters advance on each accepted input word:
//   - rf_idx increments.
//   - When rf_idx == NUM_RF-1, rf_idx returns to 0 and addr increments.
//   - addr wraps modulo 2^ADDRW (511 -> 0).
// - S_TLAST on a word that is not the final word: the word is still emitted, ERR=1, and the load terminates via DRAIN/FINISH.
// - S_TLAST on the final word is normal completion, with no ERR. S_TLAST missing on the final word is also normal completion.
// - CFG_* inputs are sampled only on an accepted CFG_START. Later changes have no effect mid-load.
// TESTING
// - Base 1, NUM_RF=64, DEPTH=1, 64 words 0..63, TREADY=1:
//   - flits carry TUSER[8:0]=1, [10:9]=3, one-hot bit 11..74 in order, and TDEST=CFG_DEST.
//   - DONE pulses 2 cycles after the last flit.
// - NUM_RF=4, DEPTH=3, base 510: 12 flits with addresses 510×4, 511×4, 0×4 (wrap checked); RF select cycles 11,12,13,14.
// - Random AXIS_M_TREADY stalls (50%): no flit is lost, duplicated or changed while stalled. S_TREADY stays 0 while the register is full and stalled.
// - S_TLAST on word 5 of a 16-word load: 6 flits, ERR=1, DONE pulses. The next CFG_START clears ERR.
// - CFG_DEPTH=0: DONE pulses with no flits. CFG_START while BUSY is ignored (flit count is unchanged).
// - Assert RST for one cycle mid-load: AXIS_M_TVALID drops immediately, BUSY=0. A fresh load then completes correctly.

Source files
------------

// File: rtl/mvm_rf_weight_loader.sv
// Weight loader: turns a raw weight-word stream into single-beat AXIS RF-write flits
// for mvm_top, walking RF select first and then address, one register stage deep.
module mvm_rf_weight_loader #(
    parameter int DATAW = 107,
    parameter int IDW   = 32,
    parameter int DESTW = 12,
    parameter int USERW = 75,
    parameter int ADDRW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [DESTW-1:0] cfg_dest,
    input  logic [6:0]       cfg_num_rf,
    input  logic [9:0]       cfg_depth,
    input  logic [ADDRW-1:0] cfg_base_addr,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [DATAW-1:0] s_tdata,
    input  logic             s_tlast,
    output logic             axis_m_tvalid,
    input  logic             axis_m_tready,
    output logic [DATAW-1:0] axis_m_tdata,
    output logic [USERW-1:0] axis_m_tuser,
    output logic [DESTW-1:0] axis_m_tdest,
    output logic [IDW-1:0]   axis_m_tid,
    output logic             axis_m_tlast,
    output logic [1:0]       state_dbg
);
    localparam int NUM_RF = USERW - 11;
    localparam int RFW    = $clog2(NUM_RF);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and a presented flit is held unchanged until it is consumed.
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    state_t             state, state_nxt;
    logic [DESTW-1:0]   dest_q;
    logic [6:0]         num_rf_q;
    logic [16:0]        total_q;
    logic [16:0]        cnt_q;
    logic [RFW-1:0]     rf_idx_q;
    logic [ADDRW-1:0]   addr_q;
    logic               err_q;
    logic               out_valid;
    logic [DATAW-1:0]   out_data;
    logic [USERW-1:0]   out_user;
    logic [DESTW-1:0]   out_dest;
    logic [6:0]         num_rf_c;
    logic [NUM_RF-1:0]  sel;
    logic               start_acc;
    logic               accept;
    logic               final_word;

    assign num_rf_c   = (cfg_num_rf > 7'(NUM_RF)) ? 7'(NUM_RF) : cfg_num_rf;
    assign start_acc  = (state == IDLE) && cfg_start;
    assign s_tready   = (state == STREAM) && (!out_valid || axis_m_tready);
    assign accept     = s_tvalid && s_tready;
    assign final_word = (cnt_q == total_q - 17'd1);
    assign sel        = {{(NUM_RF-1){1'b0}}, 1'b1} << rf_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_rf == 7'd0 || cfg_depth == 10'd0) state_nxt = FINISH;
                    else                                          state_nxt = STREAM;
                end
            end
            STREAM: if (accept && (s_tlast || final_word)) state_nxt = DRAIN;
            DRAIN:  if (!out_valid) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q   <= '0;
            num_rf_q <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
            rf_idx_q <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else if (start_acc) begin
            dest_q   <= cfg_dest;
            num_rf_q <= num_rf_c;
            total_q  <= 17'(num_rf_c) * 17'(cfg_depth);
            cnt_q    <= '0;
            rf_idx_q <= '0;
            addr_q   <= cfg_base_addr;
            err_q    <= 1'b0;
        end else if (accept) begin
            cnt_q <= cnt_q + 17'd1;
            // Same address across the RF row, then step the address (wraps naturally).
            if (7'(rf_idx_q) == num_rf_q - 7'd1) begin
                rf_idx_q <= '0;
                addr_q   <= addr_q + 1'b1;
            end else begin
                rf_idx_q <= rf_idx_q + 1'b1;
            end
            if (s_tlast && !final_word) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
            out_dest  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= s_tdata;
            out_user  <= {sel, 2'b11, addr_q};
            out_dest  <= dest_q;
        end else if (axis_m_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);
    assign err           = err_q;
    assign axis_m_tvalid = out_valid;
    assign axis_m_tdata  = out_data;
    assign axis_m_tuser  = out_user;
    assign axis_m_tdest  = out_dest;
    assign axis_m_tid    = '0;
    assign axis_m_tlast  = out_valid;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mvm_rf_weight_loader.sv
// Directed bench for mvm_rf_weight_loader: drives loads, scoreboards every flit against
// hand-derived address/select/data values, and checks stalls, errors, DONE timing and reset.
module tb_mvm_rf_weight_loader;
    localparam int DATAW = 107;
    localparam int IDW   = 32;
    localparam int DESTW = 12;
    localparam int USERW = 75;
    localparam int ADDRW = 9;
    localparam int FW    = USERW + DATAW + DESTW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_start = 1'b0;
    logic [DESTW-1:0] cfg_dest = '0;
    logic [6:0]       cfg_num_rf = '0;
    logic [9:0]       cfg_depth = '0;
    logic [ADDRW-1:0] cfg_base_addr = '0;
    logic             busy, done, err;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic [DATAW-1:0] s_tdata = '0;
    logic             s_tlast = 1'b0;
    logic             axis_m_tvalid;
    logic             axis_m_tready = 1'b0;
    logic [DATAW-1:0] axis_m_tdata;
    logic [USERW-1:0] axis_m_tuser;
    logic [DESTW-1:0] axis_m_tdest;
    logic [IDW-1:0]   axis_m_tid;
    logic             axis_m_tlast;
    logic [1:0]       state_dbg;

    mvm_rf_weight_loader #(.DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dest(cfg_dest), .cfg_num_rf(cfg_num_rf),
        .cfg_depth(cfg_depth), .cfg_base_addr(cfg_base_addr), .busy(busy), .done(done), .err(err),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .axis_m_tvalid(axis_m_tvalid), .axis_m_tready(axis_m_tready), .axis_m_tdata(axis_m_tdata),
        .axis_m_tuser(axis_m_tuser), .axis_m_tdest(axis_m_tdest), .axis_m_tid(axis_m_tid),
        .axis_m_tlast(axis_m_tlast), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];
    int  cyc_n = 0;
    int  flit_cnt = 0;
    int  done_cnt = 0;
    int  done_base = 0;
    int  last_flit_cyc = 0;
    int  done_cyc = 0;
    bit  rand_ready = 1'b0;
    bit  ready_fixed = 1'b1;
    bit  stalled_prev = 1'b0;
    logic [FW-1:0] stall_flit;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_n++;

    always @(posedge clk) begin
        #1;
        axis_m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // scoreboard / monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [FW-1:0] flit;
        flit = {axis_m_tuser, axis_m_tdata, axis_m_tdest};
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (stalled_prev) begin
            check("stall_valid", 256'(axis_m_tvalid), 256'(1));
            check("stall_hold", 256'(flit), 256'(stall_flit));
        end
        if (axis_m_tvalid && !axis_m_tready) begin
            check("stall_s_tready", 256'(s_tready), 256'(0));
            stalled_prev = 1'b1;
            stall_flit   = flit;
        end else begin
            stalled_prev = 1'b0;
        end
        if (axis_m_tvalid && axis_m_tready) begin
            flit_cnt++;
            last_flit_cyc = cyc_n;
            check("tlast", 256'(axis_m_tlast), 256'(1));
            check("tid", 256'(axis_m_tid), 256'(0));
            if (exp_q.size() == 0) check("extra_flit", 256'(1), 256'(0));
            else                   check("flit", 256'(flit), 256'(exp_q.pop_front()));
        end
    end

    function automatic logic [FW-1:0] exp_flit(input int base, input int nrf, input int i,
                                               input logic [DATAW-1:0] data, input logic [DESTW-1:0] dest);
        logic [ADDRW-1:0] a;
        logic [USERW-11-1:0] onehot;
        a = ADDRW'((base + i / nrf) % 512);
        onehot = '0;
        onehot[i % nrf] = 1'b1;
        return {onehot, 2'b11, a, data, dest};
    endfunction

    // driver: start pulse, then garbage on cfg_* to prove they are latched
    task automatic do_load(input int base, input logic [6:0] nrf_cfg, input int nrf_eff,
                           input logic [9:0] depth, input int nwords, input int tlast_at,
                           input logic [DESTW-1:0] dest, input bit seq_data, input bit busy_poke);
        logic [127:0] r;
        int guard;
        bit acc;
        done_base     = done_cnt;
        cfg_dest      = dest;
        cfg_num_rf    = nrf_cfg;
        cfg_depth     = depth;
        cfg_base_addr = ADDRW'(base);
        cfg_start     = 1'b1;
        @(posedge clk); #2;
        cfg_start     = 1'b0;
        cfg_dest      = ~dest;
        cfg_num_rf    = 7'd1;
        cfg_depth     = 10'd1;
        cfg_base_addr = '0;
        for (int i = 0; i < nwords; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_tdata  = seq_data ? DATAW'(i) : r[DATAW-1:0];
            s_tvalid = 1'b1;
            s_tlast  = (i == tlast_at);
            if (busy_poke && i == 3) begin
                cfg_start = 1'b1;
                cfg_depth = 10'd0;
            end
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                acc = s_tready;
                @(posedge clk); #2;
                cfg_start = 1'b0;
                guard++;
            end
            if (!acc) begin
                check("accept_timeout", 256'(0), 256'(1));
                break;
            end
            exp_q.push_back(exp_flit(base, nrf_eff, i, s_tdata, dest));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt == done_base && guard < 500) begin
            @(posedge clk); #2;
            guard++;
        end
        if (done_cnt == done_base) check("done_timeout", 256'(0), 256'(1));
        repeat (2) @(posedge clk);
        #2;
        check("exp_q_empty", 256'(exp_q.size()), 256'(0));
        check("idle_after_done", 256'(busy), 256'(0));
    endtask

    initial begin
        int f0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_tvalid", 256'(axis_m_tvalid), 256'(0));
        check("rst_s_tready", 256'(s_tready), 256'(0));
        check("rst_state", 256'(state_dbg), 256'(0));
        rst = 1'b0;
        @(posedge clk); #2;

        // 64 RFs, one row at base 1, sequential data, no stalls
        f0 = flit_cnt;
        do_load(1, 7'd64, 64, 10'd1, 64, -1, 12'hA5C, 1'b1, 1'b0);
        wait_done();
        check("t1_flits", 256'(flit_cnt - f0), 256'(64));
        check("t1_done_latency", 256'(done_cyc - last_flit_cyc), 256'(2));
        check("t1_err", 256'(err), 256'(0));

        // address wrap 510 -> 511 -> 0
        f0 = flit_cnt;
        do_load(510, 7'd4, 4, 10'd3, 12, 11, 12'h003, 1'b0, 1'b0);
        wait_done();
        check("t2_flits", 256'(flit_cnt - f0), 256'(12));
        check("t2_err", 256'(err), 256'(0));

        // random output stalls with an ignored start mid-load
        rand_ready = 1'b1;
        f0 = flit_cnt;
        do_load(100, 7'd5, 5, 10'd4, 20, -1, 12'h7F1, 1'b0, 1'b1);
        wait_done();
        rand_ready = 1'b0;
        check("t3_flits", 256'(flit_cnt - f0), 256'(20));

        // early TLAST on word 5 of 16; surplus word must stay upstream
        f0 = flit_cnt;
        do_load(20, 7'd4, 4, 10'd4, 6, 5, 12'h0F0, 1'b0, 1'b0);
        s_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_surplus_s_tready", 256'(s_tready), 256'(0));
            @(posedge clk); #2;
        end
        s_tvalid = 1'b0;
        wait_done();
        check("t4_flits", 256'(flit_cnt - f0), 256'(6));
        check("t4_err", 256'(err), 256'(1));

        // depth 0: DONE with no flits, ERR cleared by the start
        f0 = flit_cnt;
        do_load(0, 7'd8, 8, 10'd0, 0, -1, 12'h001, 1'b0, 1'b0);
        wait_done();
        check("t5_flits", 256'(flit_cnt - f0), 256'(0));
        check("t5_done", 256'(done_cnt - done_base), 256'(1));
        check("t5_err", 256'(err), 256'(0));

        // NUM_RF above 64 clamps to 64
        f0 = flit_cnt;
        do_load(300, 7'd100, 64, 10'd1, 64, -1, 12'h222, 1'b0, 1'b0);
        wait_done();
        check("t6_flits", 256'(flit_cnt - f0), 256'(64));

        // reset mid-load drops the flit, then a fresh load
        do_load(0, 7'd3, 3, 10'd4, 5, -1, 12'h055, 1'b0, 1'b0);
        check("t7_pre_rst_valid", 256'(axis_m_tvalid), 256'(1));
        rst = 1'b1;
        #1;
        check("t7_rst_valid", 256'(axis_m_tvalid), 256'(0));
        check("t7_rst_busy", 256'(busy), 256'(0));
        check("t7_rst_state", 256'(state_dbg), 256'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
        f0 = flit_cnt;
        do_load(7, 7'd3, 3, 10'd2, 6, 5, 12'h066, 1'b0, 1'b0);
        wait_done();
        check("t7_flits", 256'(flit_cnt - f0), 256'(6));
        check("t7_err", 256'(err), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
